// File: rtl/sap_core_p.sv
// SAP CPU core with internal writable RAM, carry/zero flags, conditional jumps,
// store, explicit output and halt. RAM is loaded through the program port while in reset.
module sap_core_p #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              halted,
   output logic              flag_c,
   output logic              flag_z,
   output logic [ADDR_W-1:0] pc
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [3:0] OP_JMP = 4'h1;
   localparam logic [3:0] OP_LDA = 4'h2;
   localparam logic [3:0] OP_LDB = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_ADD = 4'h5;
   localparam logic [3:0] OP_SUB = 4'h6;
   localparam logic [3:0] OP_STA = 4'h7;
   localparam logic [3:0] OP_OUT = 4'h8;
   localparam logic [3:0] OP_JC  = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {ST_F0, ST_F1, ST_E0, ST_E1, ST_HALT} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] mar_reg, mar_next;
   logic [DATA_W-1:0] ir_reg, ir_next;
   logic [DATA_W-1:0] a_reg, a_next;
   logic [DATA_W-1:0] b_reg, b_next;
   logic [DATA_W-1:0] out_reg, out_next;
   logic              c_reg, c_next;
   logic              z_reg, z_next;
   logic              out_valid_reg, out_valid_next;
   logic              halted_reg, halted_next;

   logic [DATA_W-1:0] ram [DEPTH];
   logic [DATA_W-1:0] ram_rd;
   logic              sta_we;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_wa;
   logic [DATA_W-1:0] ram_wd;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] opr;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] diff;

   assign opcode = ir_reg[DATA_W-1 -: 4];
   assign opr    = ir_reg[ADDR_W-1:0];
   assign ram_rd = ram[mar_reg];
   assign sum    = {1'b0, a_reg} + {1'b0, b_reg};
   assign diff   = a_reg - b_reg;

   // The program port owns the RAM write path during reset, so an STA cut short by reset never lands.
   assign ram_we = reset ? prog_we   : sta_we;
   assign ram_wa = reset ? prog_addr : mar_reg;
   assign ram_wd = reset ? prog_data : a_reg;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_wa] <= ram_wd;
      end
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      mar_next       = mar_reg;
      ir_next        = ir_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      out_next       = out_reg;
      c_next         = c_reg;
      z_next         = z_reg;
      out_valid_next = 1'b0;
      halted_next    = halted_reg;
      sta_we         = 1'b0;

      case (state_reg)
         ST_F0: begin
            mar_next   = pc_reg;
            state_next = ST_F1;
         end
         ST_F1: begin
            ir_next    = ram_rd;
            pc_next    = pc_reg + ADDR_W'(1);
            state_next = ST_E0;
         end
         ST_E0: begin
            state_next = ST_F0;
            case (opcode)
               OP_JMP: pc_next = opr;
               OP_LDA, OP_LDB, OP_STA: begin
                  mar_next   = opr;
                  state_next = ST_E1;
               end
               OP_LDI: a_next = DATA_W'(opr);
               OP_ADD: begin
                  {c_next, a_next} = sum;
                  z_next           = (sum[DATA_W-1:0] == '0);
               end
               OP_SUB: begin
                  a_next = diff;
                  c_next = (a_reg >= b_reg);
                  z_next = (diff == '0);
               end
               OP_OUT: begin
                  out_next       = a_reg;
                  out_valid_next = 1'b1;
               end
               OP_JC: if (c_reg) pc_next = opr;
               OP_JZ: if (z_reg) pc_next = opr;
               OP_HLT: begin
                  halted_next = 1'b1;
                  state_next  = ST_HALT;
               end
               default: ;
            endcase
         end
         ST_E1: begin
            state_next = ST_F0;
            case (opcode)
               OP_LDA:  a_next = ram_rd;
               OP_LDB:  b_next = ram_rd;
               OP_STA:  sta_we = 1'b1;
               default: ;
            endcase
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_F0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_F0;
         pc_reg        <= '0;
         mar_reg       <= '0;
         ir_reg        <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         out_reg       <= '0;
         c_reg         <= 1'b0;
         z_reg         <= 1'b0;
         out_valid_reg <= 1'b0;
         halted_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         mar_reg       <= mar_next;
         ir_reg        <= ir_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         out_reg       <= out_next;
         c_reg         <= c_next;
         z_reg         <= z_next;
         out_valid_reg <= out_valid_next;
         halted_reg    <= halted_next;
      end
   end

   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign halted    = halted_reg;
   assign flag_c    = c_reg;
   assign flag_z    = z_reg;
   assign pc        = pc_reg;

endmodule

// File: tb/tb_sap_core_p.sv
// Bench for sap_core_p: directed programs plus random programs checked against an
// instruction-level reference model; a second instance covers a 12/8 configuration.
module tb_sap_core_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, prog_we = 1'b0;
   logic [3:0] prog_addr = '0;
   logic [7:0] prog_data = '0;
   logic [7:0] out;
   logic       out_valid, halted, flag_c, flag_z;
   logic [3:0] pc;

   logic        reset_w = 1'b1, prog_we_w = 1'b0;
   logic [7:0]  prog_addr_w = '0;
   logic [11:0] prog_data_w = '0;
   logic [11:0] out_w;
   logic        out_valid_w, halted_w, flag_c_w, flag_z_w;
   logic [7:0]  pc_w;

   sap_core_p #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .out(out), .out_valid(out_valid), .halted(halted),
      .flag_c(flag_c), .flag_z(flag_z), .pc(pc)
   );

   sap_core_p #(.DATA_W(12), .ADDR_W(8)) dut_w (
      .clk(clk), .reset(reset_w), .prog_we(prog_we_w), .prog_addr(prog_addr_w),
      .prog_data(prog_data_w), .out(out_w), .out_valid(out_valid_w), .halted(halted_w),
      .flag_c(flag_c_w), .flag_z(flag_z_w), .pc(pc_w)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: one whole instruction per step.
   logic [7:0] m_ram [16];
   int m_pc, m_a, m_b, m_c, m_z, m_out, m_halt;

   int edge_cnt, ov_cycle, halt_cycle;
   int         pulse_edge = -1;
   logic [3:0] pulse_addr = '0;
   logic [7:0] pulse_data = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_tick();
      if (edge_cnt == pulse_edge) begin
         prog_we   = 1'b1;
         prog_addr = pulse_addr;
         prog_data = pulse_data;
      end
      tick();
      prog_we = 1'b0;
      if (out_valid === 1'b1 && ov_cycle < 0) ov_cycle = edge_cnt + 1;
      if (halted === 1'b1 && halt_cycle < 0) halt_cycle = edge_cnt + 1;
      edge_cnt++;
   endtask

   task automatic model_step(output int cyc, output bit is_out);
      int op, opr, s;
      op     = int'(m_ram[m_pc]) / 16;
      opr    = int'(m_ram[m_pc]) % 16;
      m_pc   = (m_pc + 1) % 16;
      cyc    = 3;
      is_out = 1'b0;
      case (op)
         1: m_pc = opr;
         2: begin m_a = int'(m_ram[opr]); cyc = 4; end
         3: begin m_b = int'(m_ram[opr]); cyc = 4; end
         4: m_a = opr;
         5: begin s = m_a + m_b; m_c = (s > 255); m_a = s % 256; m_z = (m_a == 0); end
         6: begin m_c = (m_a >= m_b); m_a = (m_a - m_b + 256) % 256; m_z = (m_a == 0); end
         7: begin m_ram[opr] = 8'(m_a); cyc = 4; end
         8: begin m_out = m_a; is_out = 1'b1; end
         9: if (m_c != 0) m_pc = opr;
         10: if (m_z != 0) m_pc = opr;
         15: m_halt = 1;
         default: ;
      endcase
   endtask

   task automatic load_image(input logic [15:0] load_en);
      reset   = 1'b1;
      prog_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (load_en[i]) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = m_ram[i];
            tick();
         end
      end
      prog_we = 1'b0;
      tick();
   endtask

   task automatic run_prog(input string name, input logic [15:0] load_en, input int max_instr);
      int cyc;
      bit is_out;
      load_image(load_en);
      chk($sformatf("%s reset_state", name), {pc, out, out_valid, halted, flag_c, flag_z}, 32'h0);
      m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_z = 0; m_out = 0; m_halt = 0;
      edge_cnt = 0; ov_cycle = -1; halt_cycle = -1;
      reset = 1'b0;
      for (int n = 0; n < max_instr && m_halt == 0; n++) begin
         model_step(cyc, is_out);
         for (int k = 1; k <= cyc; k++) begin
            cpu_tick();
            if (k < cyc) chk($sformatf("%s i%0d ov_mid", name, n), out_valid, 1'b0);
         end
         chk($sformatf("%s i%0d pc", name, n), pc, m_pc);
         chk($sformatf("%s i%0d out", name, n), out, m_out);
         chk($sformatf("%s i%0d hcz_ov", name, n), {halted, flag_c, flag_z, out_valid},
             {m_halt[0], m_c[0], m_z[0], is_out});
      end
      if (m_halt != 0) begin
         for (int k = 0; k < 4; k++) begin
            cpu_tick();
            chk($sformatf("%s hold%0d", name, k), {pc, halted, out_valid}, {m_pc[3:0], 2'b10});
         end
      end
   endtask

   task automatic clear_ram();
      for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
   endtask

   initial begin
      int w_addr [8];
      int w_data [8];

      // ADD, OUT, HLT with cycle-exact pulse and halt timing
      clear_ram();
      m_ram[0] = 8'h2F; m_ram[1] = 8'h3E; m_ram[2] = 8'h50; m_ram[3] = 8'h80; m_ram[4] = 8'hF0;
      m_ram[14] = 8'h42; m_ram[15] = 8'h1E;
      run_prog("t1", 16'hFFFF, 20);
      chk("t1 out_valid_cycle", ov_cycle, 14);
      chk("t1 halt_cycle", halt_cycle, 17);
      chk("t1 out", out, 8'h60);
      chk("t1 pc_frozen", pc, 4'h5);
      chk("t1 cz", {flag_c, flag_z}, 2'b00);

      // carry into JC: taken then not taken
      clear_ram();
      m_ram[0] = 8'h2E; m_ram[1] = 8'h3F; m_ram[2] = 8'h50; m_ram[3] = 8'h98; m_ram[4] = 8'hF0;
      m_ram[8] = 8'h80; m_ram[9] = 8'hF0; m_ram[14] = 8'hFF; m_ram[15] = 8'h01;
      run_prog("t2a", 16'hFFFF, 20);
      chk("t2a pc", pc, 4'hA);
      chk("t2a cz", {flag_c, flag_z}, 2'b11);
      chk("t2a out", out, 8'h00);
      m_ram[14] = 8'h01;
      run_prog("t2b", 16'hFFFF, 20);
      chk("t2b pc", pc, 4'h5);
      chk("t2b cz", {flag_c, flag_z}, 2'b00);

      // SUB borrow into JZ: not taken then taken
      clear_ram();
      m_ram[0] = 8'h2E; m_ram[1] = 8'h3F; m_ram[2] = 8'h60; m_ram[3] = 8'hA9; m_ram[4] = 8'h80;
      m_ram[5] = 8'hF0; m_ram[9] = 8'h80; m_ram[10] = 8'hF0; m_ram[14] = 8'h05; m_ram[15] = 8'h07;
      run_prog("t3a", 16'hFFFF, 20);
      chk("t3a out", out, 8'hFE);
      chk("t3a cz", {flag_c, flag_z}, 2'b00);
      chk("t3a pc", pc, 4'h6);
      m_ram[14] = 8'h07;
      run_prog("t3b", 16'hFFFF, 20);
      chk("t3b out", out, 8'h00);
      chk("t3b cz", {flag_c, flag_z}, 2'b11);
      chk("t3b pc", pc, 4'hB);

      // store round trip, read back through B and A
      clear_ram();
      m_ram[0] = 8'h49; m_ram[1] = 8'h7D; m_ram[2] = 8'h3D; m_ram[3] = 8'h50;
      m_ram[4] = 8'h80; m_ram[5] = 8'h2D; m_ram[6] = 8'h80; m_ram[7] = 8'hF0;
      run_prog("t4a", 16'hFFFF, 20);
      chk("t4a ram_d", out, 8'h09);

      // reset lands on the STA E1 edge (edge 9): write must be dropped
      clear_ram();
      m_ram[0] = 8'h49; m_ram[1] = 8'h80; m_ram[2] = 8'h7D; m_ram[13] = 8'h55;
      load_image(16'hFFFF);
      reset = 1'b0;
      for (int e = 0; e < 9; e++) tick();
      chk("t4b pre_out", out, 8'h09);
      chk("t4b pre_pc", pc, 4'h3);
      reset = 1'b1;
      tick();
      chk("t4b abort_state", {pc, out, out_valid, halted, flag_c, flag_z}, 32'h0);
      m_ram[0] = 8'h2D; m_ram[1] = 8'h80; m_ram[2] = 8'hF0;
      run_prog("t4c", 16'h0007, 10);
      chk("t4c ram_d_kept", out, 8'h55);

      // NOP sweep wraps pc; a prog_we pulse outside reset must be ignored
      clear_ram();
      pulse_edge = 5; pulse_addr = 4'hA; pulse_data = 8'hF0;
      run_prog("t5", 16'hFFFF, 17);
      pulse_edge = -1;
      chk("t5 pc_wrapped", pc, 4'h1);
      chk("t5 not_halted", halted, 1'b0);

      // random programs against the model
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 16; i++) m_ram[i] = 8'($urandom);
         run_prog($sformatf("rnd%0d", r), 16'hFFFF, 25);
      end

      // 12-bit data / 8-bit address instance
      reset = 1'b1;
      w_addr = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF0, 8'hF1, 8'hFF};
      w_data = '{12'h2F0, 12'h3F1, 12'h500, 12'h800, 12'h1FF, 12'hFFF, 12'h001, 12'h000};
      reset_w = 1'b1;
      for (int i = 0; i < 8; i++) begin
         prog_we_w   = 1'b1;
         prog_addr_w = 8'(w_addr[i]);
         prog_data_w = 12'(w_data[i]);
         tick();
      end
      prog_we_w = 1'b0;
      tick();
      chk("t6 reset_state", {pc_w, out_w, out_valid_w, halted_w, flag_c_w, flag_z_w}, 32'h0);
      reset_w = 1'b0;
      for (int e = 0; e < 20; e++) begin
         tick();
         if (e == 12) chk("t6 ov_before", out_valid_w, 1'b0);
         if (e == 13) begin
            chk("t6 ov_cz", {out_valid_w, flag_c_w, flag_z_w}, 3'b111);
            chk("t6 out", out_w, 12'h000);
            chk("t6 pc_out", pc_w, 8'h04);
         end
         if (e == 14) chk("t6 ov_after", out_valid_w, 1'b0);
         if (e == 16) chk("t6 pc_jmp", pc_w, 8'hFF);
         if (e == 19) chk("t6 pc_wrap", pc_w, 8'h00);
      end
      chk("t6 not_halted", halted_w, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sap_core_p.md
Name: sap_core_p

Overview:
- Parametrised next-generation SAP CPU core with internal writable RAM, carry/zero flags, conditional jumps, store, explicit output and halt.
- Instruction word is {opcode[3:0], operand[ADDR_W-1:0]}; all state updates on posedge clk, with no negedge logic.
- The RAM is loaded through a program port while reset is held.
- Sits at the top of the SAP datapath in place of the fixed 8-bit/4-bit machine.

Parameters:
DATA_W, 8, data/accumulator width; must be >= ADDR_W+4
ADDR_W, 4, address width; RAM depth = 2**ADDR_W words of DATA_W bits

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
prog_we  in  1  RAM write strobe; honoured only while reset=1
prog_addr  in  ADDR_W  RAM write address for program load
prog_data  in  DATA_W  RAM write data for program load
out  out  DATA_W  output register
out_valid  out  1  one-cycle pulse when out is updated
halted  out  1  high once HLT has executed
flag_c  out  1  carry flag
flag_z  out  1  zero flag
pc  out  ADDR_W  program counter (debug)

Behaviour:
- Reset (sync, highest priority): PC, MAR, IR, A, B, out, flag_c, flag_z, out_valid, halted all go to 0; state goes to F0. RAM contents are not cleared.
- Program load: with reset=1 and prog_we=1, RAM[prog_addr] <= prog_data at the edge. prog_we is ignored when reset=0.
- RAM read is combinational from MAR. RAM write is synchronous (STA only).
- States: F0, F1, E0, E1, HALT.
- F0: MAR<=PC; next F1.
- F1: IR<=RAM[MAR]; PC<=PC+1, wrapping from 2**ADDR_W-1 to 0; next E0.
- E0, decoded on IR[DATA_W-1:DATA_W-4]; opr = IR[ADDR_W-1:0]:
  - 0 NOP: no effect; next F0.
  - 1 JMP: PC<=opr.
  - 2 LDA, 3 LDB, 7 STA: MAR<=opr; next E1.
  - 4 LDI: A<=zero-extended opr.
  - 5 ADD: {C,A}<=A+B, computed DATA_W+1 bits wide; Z<=(sum==0).
  - 6 SUB: A<=A-B mod 2**DATA_W; C<=(A>=B), unsigned, meaning no borrow; Z<=(diff==0).
  - 8 OUT: out<=A; out_valid=1 in the following cycle only.
  - 9 JC: PC<=opr if C=1. A JZ: PC<=opr if Z=1. A jump not taken falls through.
  - F HLT: halted<=1; next HALT.
  - B-E: treated as NOP.
  - Every E0 except LDA/LDB/STA/HLT goes to F0 next.
- E1: LDA A<=RAM[MAR]; LDB B<=RAM[MAR]; STA RAM[MAR]<=A. Next F0.
- HALT: holds every register; only reset exits.
- Flags change only on ADD/SUB.
- Latency: 3 cycles per instruction, 4 cycles for LDA/LDB/STA.
- Cycle 0 is the first edge with reset=0.
- Reset asserted mid-instruction aborts it. A STA whose E1 coincides with reset does not write.
- out_valid is 0 in every cycle except the one following an OUT E0.

Test Plan:
1. ADD/OUT/HLT. Load RAM[0..4] = LDA F, LDB E, ADD, OUT, HLT; RAM[E]=0x42, RAM[F]=0x1E.
   -> A=0x60, C=0, Z=0; out=0x60 with out_valid high only in cycle 14; halted=1 from cycle 17 and stays; pc frozen at 5.
2. Carry and conditional jump. Data 0xFF and 0x01; LDA, LDB, ADD, JC 8.
   -> A=0x00, C=1, Z=1; JC taken, pc=8 after its E0. Repeat with 0x01+0x01: JC falls through.
3. SUB borrow. A=0x05, B=0x07, SUB, JZ 9.
   -> A=0xFE, C=0, Z=0; JZ not taken. Also 0x07-0x07 -> A=0, C=1, Z=1, JZ taken.
4. Store round-trip. LDI 0x9, STA D, LDB D.
   -> RAM[D]=0x09, B=0x09.
   Second run: assert reset during the STA E1 cycle; RAM[D] keeps its prior value and all registers read 0.
5. PC wrap. RAM filled with NOP.
   -> pc counts 1..15 then 0; every instruction takes 3 cycles.
   prog_we pulsed while reset=0 leaves RAM unchanged.
6. Width generalisation. DATA_W=12, ADDR_W=8: LDA 0xF0 (RAM=0xFFF), LDB 0xF1 (RAM=0x001), ADD, OUT.
   -> out=0x000, C=1, Z=1; JMP 0xFF followed by a NOP at 0xFF wraps pc to 0x00.
